sync_fifo_p: RTL and testbench

Parametrised single-clock FIFO, next generation of the team's 8-bit buffer. Generic width and depth, true full-depth occupancy (2**ADDR_WIDTH entries), programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush. Sits between a producer and a consumer in the same clock domain, e.g. UART/SPI byte paths and packet staging.

---
 rtl/sync_fifo_p_if.sv | 28 ++
 rtl/sync_fifo_p.sv | 81 ++++++++
 tb/tb_sync_fifo_p.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_p_if.sv
// Handshake and status bundle between a producer/consumer pair and sync_fifo_p.
interface sync_fifo_p_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  clr;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   cnt;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output clr, wr_en, data_in, rd_en,
    input  data_out, full, empty, almost_full, almost_empty, cnt, overflow, underflow
  );

  modport slave (
    input  clr, wr_en, data_in, rd_en,
    output data_out, full, empty, almost_full, almost_empty, cnt, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_p.sv
// Single-clock FIFO with full 2**ADDR_WIDTH occupancy, programmable almost flags and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through output; otherwise data_out is registered.
module sync_fifo_p #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  sync_fifo_p_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_cnt;
  logic                  r_ovf;
  logic                  r_udf;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr;
  logic                  w_rd;

  assign w_full  = (r_cnt == DEPTH_C);
  assign w_empty = (r_cnt == '0);
  assign w_wr    = bus.wr_en && !w_full;
  assign w_rd    = bus.rd_en && !w_empty;

  // Occupancy is the single source of truth for every status flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else if (bus.clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_wr && !w_rd)      r_cnt <= r_cnt + 1'b1;
      else if (w_rd && !w_wr) r_cnt <= r_cnt - 1'b1;
      if (bus.wr_en && w_full)  r_ovf <= 1'b1;
      if (bus.rd_en && w_empty) r_udf <= 1'b1;
    end
  end

  // Storage is deliberately left unreset so it maps onto plain RAM.
  always_ff @(posedge i_clk) begin
    if (w_wr && !bus.clr) r_mem[r_wr_ptr] <= bus.data_in;
  end

`ifdef FIFO_FWFT_EN
  assign bus.data_out = w_empty ? '0 : r_mem[r_rd_ptr];
`else
  logic [DATA_WIDTH-1:0] r_dout;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)               r_dout <= '0;
    else if (w_rd && !bus.clr)  r_dout <= r_mem[r_rd_ptr];
  end

  assign bus.data_out = r_dout;
`endif

  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (32'(r_cnt) >= AF_LEVEL);
  assign bus.almost_empty = (32'(r_cnt) <= AE_LEVEL);
  assign bus.cnt          = r_cnt;
  assign bus.overflow     = r_ovf;
  assign bus.underflow    = r_udf;
endmodule

// File: tb/tb_sync_fifo_p.sv
// Randomised and directed bench for sync_fifo_p against a queue-based reference model.
module tb_sync_fifo_p;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int DEPTH = 1 << AW;
  localparam int AF = DEPTH - 2;
  localparam int AE = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  bit   cmp_en = 1'b0;

  sync_fifo_p_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sync_fifo_p #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference model: a queue plus the sticky bits and the last popped word.
  logic [DW-1:0] q [$];
  bit            m_ovf, m_udf;
  logic [DW-1:0] m_dout;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      m_dout = '0;
    end else if (bus.clr) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      bit was_full, was_empty;
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      if (bus.wr_en && was_full)  m_ovf = 1'b1;
      if (bus.rd_en && was_empty) m_udf = 1'b1;
      if (bus.rd_en && !was_empty) m_dout = q.pop_front();
      if (bus.wr_en && !was_full)  q.push_back(bus.data_in);
    end
  end

  function automatic logic [DW-1:0] exp_dout();
`ifdef FIFO_FWFT_EN
    return (q.size() == 0) ? '0 : q[0];
`else
    return m_dout;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      chk("cnt",          32'(bus.cnt),      32'(q.size()));
      chk("full",         32'(bus.full),     32'(q.size() == DEPTH));
      chk("empty",        32'(bus.empty),    32'(q.size() == 0));
      chk("almost_full",  32'(bus.almost_full),  32'(q.size() >= AF));
      chk("almost_empty", 32'(bus.almost_empty), 32'(q.size() <= AE));
      chk("overflow",     32'(bus.overflow),  32'(m_ovf));
      chk("underflow",    32'(bus.underflow), 32'(m_udf));
      chk("data_out",     32'(bus.data_out),  32'(exp_dout()));
    end
  end

  // Called at a falling edge: apply inputs, let one rising edge act, return at the next falling edge.
  task automatic tick(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
    bus.wr_en = w; bus.data_in = d; bus.rd_en = r; bus.clr = c;
    @(negedge clk);
  endtask

  initial begin
    bus.wr_en = 0; bus.data_in = '0; bus.rd_en = 0; bus.clr = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    chk("rst_cnt",   32'(bus.cnt), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_ae",    32'(bus.almost_empty), 1);
    chk("rst_full",  32'(bus.full), 0);
    chk("rst_dout",  32'(bus.data_out), 0);

    tick(1, 8'h11, 0, 0);
    tick(1, 8'h22, 0, 0);
    tick(1, 8'h33, 0, 0);
    chk("three_cnt", 32'(bus.cnt), 3);
`ifdef FIFO_FWFT_EN
    chk("fwft_head", 32'(bus.data_out), 32'h11);
    tick(0, 0, 1, 0); chk("rd1", 32'(bus.data_out), 32'h22);
    tick(0, 0, 1, 0); chk("rd2", 32'(bus.data_out), 32'h33);
    tick(0, 0, 1, 0); chk("rd3", 32'(bus.data_out), 32'h00);
`else
    tick(0, 0, 1, 0); chk("rd1", 32'(bus.data_out), 32'h11);
    tick(0, 0, 1, 0); chk("rd2", 32'(bus.data_out), 32'h22);
    tick(0, 0, 1, 0); chk("rd3", 32'(bus.data_out), 32'h33);
`endif
    chk("drained_empty", 32'(bus.empty), 1);

    for (int i = 0; i < DEPTH; i++) tick(1, DW'(i), 0, 0);
    chk("fill_full", 32'(bus.full), 1);
    chk("fill_cnt",  32'(bus.cnt), DEPTH);
    tick(1, 8'hAA, 1, 0);
    chk("ovf_set",   32'(bus.overflow), 1);
    chk("ovf_cnt",   32'(bus.cnt), DEPTH - 1);
    tick(1, 8'hAA, 0, 0);
    chk("ovf_cnt_full", 32'(bus.cnt), DEPTH);
    for (int i = 0; i < DEPTH; i++) tick(0, 0, 1, 0);
    chk("drain_empty", 32'(bus.empty), 1);

    tick(0, 0, 1, 0);
    chk("udf_set", 32'(bus.underflow), 1);
    chk("udf_cnt", 32'(bus.cnt), 0);
    tick(0, 0, 0, 1);
    chk("clr_udf", 32'(bus.underflow), 0);
    chk("clr_ovf", 32'(bus.overflow), 0);

    for (int i = 0; i < 5; i++) tick(1, DW'($urandom), 0, 0);
    for (int i = 0; i < 300; i++) tick(1, DW'($urandom), 1, 0);
    chk("stream_cnt", 32'(bus.cnt), 5);
    tick(0, 0, 0, 1);

    for (int i = 0; i < 253; i++) tick(1, DW'($urandom), 0, 0);
    chk("af_253", 32'(bus.almost_full), 0);
    tick(1, DW'($urandom), 0, 0);
    chk("af_254", 32'(bus.almost_full), 1);
    for (int i = 0; i < 251; i++) tick(0, 0, 1, 0);
    chk("ae_3", 32'(bus.almost_empty), 0);
    tick(0, 0, 1, 0);
    chk("ae_2", 32'(bus.almost_empty), 1);
    tick(0, 0, 0, 1);

    for (int i = 0; i < 100; i++) tick(1, DW'(i + 7), 1'(i % 3 == 0 && i > 0), 0);
    for (int i = 0; i < 33; i++) tick(1, DW'($urandom), 0, 0);
    chk("pre_rst_cnt", 32'(bus.cnt), 100);
    #2 rst_n = 1'b0;
    #1;
    chk("async_cnt",   32'(bus.cnt), 0);
    chk("async_empty", 32'(bus.empty), 1);
    chk("async_dout",  32'(bus.data_out), 0);
    chk("async_ovf",   32'(bus.overflow), 0);
    bus.wr_en = 0; bus.rd_en = 0;
    @(negedge clk);
    rst_n = 1'b1;

    tick(1, 8'h5A, 0, 0);
`ifdef FIFO_FWFT_EN
    chk("fwft_5a", 32'(bus.data_out), 32'h5A);
`else
    chk("reg_hold_0", 32'(bus.data_out), 0);
`endif
    tick(0, 0, 0, 1);

    for (int i = 0; i < 3000; i++) begin
      int mode;
      mode = (i / 500) % 3;
      tick(($urandom_range(0, 9) < (mode == 0 ? 8 : (mode == 1 ? 2 : 5))),
           DW'($urandom),
           ($urandom_range(0, 9) < (mode == 0 ? 2 : (mode == 1 ? 8 : 5))),
           ($urandom_range(0, 299) == 0));
    end
    tick(0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
